// File: rtl/gemm_pkg.sv
// gemm_pkg: shared types, default sizes and index-width helper for the gemm blocks
package gemm_pkg;
  typedef enum logic {IDLE, STREAM} streamer_state_t;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_MATRIX_WIDTH = 4;
  localparam int DEF_MATRIX_HEIGHT = 4;
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/gemm_rc_counter.sv
// gemm_rc_counter: row-major row/col counter with enable, sync clear and terminal flag
module gemm_rc_counter #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int RW = 2,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          term_o
);
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic col_end, row_end;
  // advance column, wrapping into the next row; the last element wraps back to [0][0]
  always_comb begin
    col_end = col_q == CW'(COLS - 1);
    row_end = row_q == RW'(ROWS - 1);
    col_d = !en_i ? col_q : col_end ? '0 : col_q + CW'(1);
    row_d = (!en_i || !col_end) ? row_q : row_end ? '0 : row_q + RW'(1);
  end
  // position register, cleared by reset or explicit clear
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
  assign row_o = row_q;
  assign col_o = col_q;
  assign term_o = col_end && row_end;
endmodule

// File: rtl/gemm_result_streamer.sv
// gemm_result_streamer: snapshots a result matrix on done and streams it row-major over valid/ready
module gemm_result_streamer
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MATRIX_WIDTH = DEF_MATRIX_WIDTH,
  parameter int MATRIX_HEIGHT = DEF_MATRIX_HEIGHT,
  localparam int RW = clog2_min1(MATRIX_HEIGHT),
  localparam int CW = clog2_min1(MATRIX_WIDTH)
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  idone,
  input  logic [DATA_WIDTH-1:0] iresult_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
  output logic [DATA_WIDTH-1:0] ostream_data,
  output logic [RW-1:0]         ostream_row,
  output logic [CW-1:0]         ostream_col,
  output logic                  ostream_valid,
  input  logic                  istream_ready,
  output logic                  ostream_last,
  output logic                  obusy,
  output logic                  odone,
  output logic                  ooverrun
);
  streamer_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
  logic odone_q, ovr_q;
  logic term, hs, fin, cap;
  assign hs = ostream_valid && istream_ready;
  assign fin = hs && term;
  assign cap = idone && (state_q == IDLE || fin);
  gemm_rc_counter #(
    .ROWS(MATRIX_HEIGHT),
    .COLS(MATRIX_WIDTH),
    .RW(RW),
    .CW(CW)
  ) u_rc (
    .clk(iclk),
    .rst(irst),
    .en_i(hs),
    .clr_i(state_q == IDLE),
    .row_o(ostream_row),
    .col_o(ostream_col),
    .term_o(term)
  );
  // state, done pulse and sticky overrun flag
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= IDLE;
      odone_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      odone_q <= fin;
      ovr_q <= ovr_q || (idone && state_q == STREAM && !fin);
    end
  end
  // snapshot buffer; contents only matter once captured
  always_ff @(posedge iclk) begin
    if (cap) buf_q <= iresult_matrix;
  end
  // capture starts (or restarts) a stream; otherwise stay streaming until the final beat
  always_comb begin
    state_d = cap ? STREAM : (state_q == STREAM && !fin) ? STREAM : IDLE;
  end
  // stream outputs are zero whenever nothing is buffered
  always_comb begin
    ostream_valid = state_q == STREAM;
    obusy = ostream_valid;
    ostream_data = ostream_valid ? buf_q[ostream_row][ostream_col] : '0;
    ostream_last = ostream_valid && term;
  end
  assign odone = odone_q;
  assign ooverrun = ovr_q;
endmodule

// File: tb/tb_gemm_result_streamer.sv
// tb_gemm_result_streamer: directed table and sequence checks of the result streamer
module tb_gemm_result_streamer;
  localparam int DW = 64, M = 4, N = 4;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic idone, ready;
  logic [DW-1:0] mat [0:M-1][0:N-1];
  logic [DW-1:0] data;
  logic [1:0] row, col;
  logic valid, last, busy, done, ovr;
  logic idone1, ready1;
  logic [DW-1:0] mat1 [0:0][0:0];
  logic [DW-1:0] data1;
  logic row1, col1, valid1, last1, busy1, done1, ovr1;

  gemm_result_streamer #(.DATA_WIDTH(DW), .MATRIX_WIDTH(N), .MATRIX_HEIGHT(M)) dut (
    .iclk(clk), .irst(rst), .idone(idone), .iresult_matrix(mat),
    .ostream_data(data), .ostream_row(row), .ostream_col(col), .ostream_valid(valid),
    .istream_ready(ready), .ostream_last(last), .obusy(busy), .odone(done), .ooverrun(ovr));

  gemm_result_streamer #(.DATA_WIDTH(DW), .MATRIX_WIDTH(1), .MATRIX_HEIGHT(1)) dut1 (
    .iclk(clk), .irst(rst), .idone(idone1), .iresult_matrix(mat1),
    .ostream_data(data1), .ostream_row(row1), .ostream_col(col1), .ostream_valid(valid1),
    .istream_ready(ready1), .ostream_last(last1), .obusy(busy1), .odone(done1), .ooverrun(ovr1));

  typedef struct {
    logic dn_in;
    logic rdy;
    logic [DW-1:0] d;
    int r, c;
    logic v, l, b, dn, ov;
  } vec_t;
  vec_t tbl [19];
  int nvec = 0, nerr = 0;

  function automatic logic [72:0] pk(logic [63:0] d, logic [1:0] r, logic [1:0] c, logic v, logic l, logic b, logic dn, logic ov);
    return {d, r, c, v, l, b, dn, ov};
  endfunction

  task automatic cmp(input string nm, input logic [72:0] a, input logic [72:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got {data,row,col,v,l,b,dn,ov}=%h expected %h", nm, a, e);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] d, input int r, input int c, input logic v, input logic l, input logic b, input logic dn, input logic ov);
    cmp(nm, pk(data, row, col, valid, last, busy, done, ovr), pk(d, 2'(r), 2'(c), v, l, b, dn, ov));
  endtask

  task automatic load_a();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) mat[i][j] = 64'(i * 4 + j + 1);
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) mat[i][j] = v;
  endtask

  initial begin
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k, cyc;
    rst = 1'b1; idone = 1'b0; ready = 1'b0; idone1 = 1'b0; ready1 = 1'b0;
    load_a();
    mat1[0][0] = '1;
    tbl[0] = '{1'b1, 1'b1, 64'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 1; i <= 16; i++)
      tbl[i] = '{1'b0, 1'b1, 64'(i), (i - 1) / 4, (i - 1) % 4, 1'b1, i == 16, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 64'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 64'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // full-throughput stream from reset
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      idone = tbl[i].dn_in; ready = tbl[i].rdy;
      #1 chk($sformatf("s1[%0d]", i), tbl[i].d, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].l, tbl[i].b, tbl[i].dn, tbl[i].ov);
    end
    // backpressure: element must hold until accepted
    @(negedge clk); idone = 1'b1; ready = 1'b0;
    #1 chk("s2 idle", 0, 0, 0, 0, 0, 0, 0, 0);
    k = 0; cyc = 0;
    while (k < 16 && cyc < 200) begin
      @(negedge clk);
      idone = 1'b0;
      ready = (cyc < 4) ? pat[cyc] : 1'($urandom_range(0, 1));
      #1 chk($sformatf("s2 beat%0d cyc%0d", k, cyc), 64'(k + 1), k / 4, k % 4, 1, k == 15, 1, 0, 0);
      if (ready) k++;
      cyc++;
    end
    cmp("s2 beats", 73'(k), 73'd16);
    @(negedge clk); ready = 1'b1;
    #1 chk("s2 done", 0, 0, 0, 0, 0, 0, 1, 0);
    // back-to-back capture on the final handshake
    @(negedge clk); idone = 1'b1;
    #1 chk("s4 idle", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idone = i == 15;
      if (i == 15) fill(64'd7);
      #1 chk($sformatf("s4 a%0d", i), 64'(i + 1), i / 4, i % 4, 1, i == 15, 1, 0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idone = 1'b0;
      #1 chk($sformatf("s4 b%0d", i), 64'd7, i / 4, i % 4, 1, i == 15, 1, i == 0, 0);
    end
    @(negedge clk);
    #1 chk("s4 done", 0, 0, 0, 0, 0, 0, 1, 0);
    // snapshot isolation and overrun on a dropped done
    load_a();
    @(negedge clk); idone = 1'b1;
    #1 chk("s3 idle", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idone = i == 4;
      if (i == 1) fill(64'hFFFF_FFFF_FFFF_FFFB);
      #1 chk($sformatf("s3 b%0d", i), 64'(i + 1), i / 4, i % 4, 1, i == 15, 1, 0, i > 4);
    end
    @(negedge clk); idone = 1'b0;
    #1 chk("s3 done", 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("s3 sticky%0d", i), 0, 0, 0, 0, 0, 0, 0, 1);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 chk("s3 ovr cleared", 0, 0, 0, 0, 0, 0, 0, 0);
    // reset mid-stream aborts without done, then a fresh start
    load_a();
    @(negedge clk); idone = 1'b1;
    #1 chk("s5 idle", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      idone = 1'b0; rst = i == 8;
      #1 chk($sformatf("s5 b%0d", i), 64'(i + 1), i / 4, i % 4, 1, 0, 1, 0, 0);
    end
    @(negedge clk); rst = 1'b0;
    #1 chk("s5 abort", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); idone = 1'b1;
    #1 chk("s5 no done", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); idone = 1'b0;
    #1 chk("s5 restart", 64'd1, 0, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    #1 chk("s5 second", 64'd2, 0, 1, 1, 0, 1, 0, 0);
    // degenerate 1x1 matrix
    @(negedge clk); idone1 = 1'b1; ready1 = 1'b1;
    #1 cmp("s6 idle", pk(data1, {1'b0, row1}, {1'b0, col1}, valid1, last1, busy1, done1, ovr1), pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); idone1 = 1'b0;
    #1 cmp("s6 beat", pk(data1, {1'b0, row1}, {1'b0, col1}, valid1, last1, busy1, done1, ovr1), pk('1, 0, 0, 1, 1, 1, 0, 0));
    @(negedge clk);
    #1 cmp("s6 done", pk(data1, {1'b0, row1}, {1'b0, col1}, valid1, last1, busy1, done1, ovr1), pk(0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    #1 cmp("s6 after", pk(data1, {1'b0, row1}, {1'b0, col1}, valid1, last1, busy1, done1, ovr1), pk(0, 0, 0, 0, 0, 0, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
